sma_inv: RTL and testbench
==========================

# sma_inv

Inverse simple-moving-average filter. Takes the stream of 4-tap running sums produced by the SMA filter and reconstructs the original sample stream bit-exactly. The recurrence is x[n] = y[n] − y[n−1] + x[n−TAPS]. It sits on the receive/analysis side of the datapath, directly downstream of any link that carries SMA output, and presents a valid/ready stream on both ends.

## Interface
Parameters:
- DATA_W, 16, sample width; signed two's complement on both ends
- TAPS, 4, SMA window length; must be ≥ 2

Ports:
- clk, in, 1, sole clock; all logic is rising-edge
- rst, in, 1, reset; synchronous and active-high
- clear, in, 1, synchronous history flush (see Operation)
- in_valid, in, 1, y sample present
- in_ready, out, 1, block accepts y this cycle
- y, in, DATA_W, signed SMA sum sample
- out_valid, out, 1, reconstructed sample present
- out_ready, in, 1, downstream accepts x this cycle
- x, out, DATA_W, signed reconstructed sample

## Operation
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- History state:
  - y_prev: one DATA_W register.
  - x_hist: a TAPS-deep shift register of previously emitted x values.
  - All history resets to 0. This matches the SMA filter's zero initial state, so no warm-up is needed.
- On accept:
  - x_new = y − y_prev + x_hist[TAPS−1], computed modulo 2^DATA_W (wrap, no saturation). Because the forward SMA also wraps, the round trip is exact for all inputs.
  - Then y_prev ← y, x_hist shifts by one with x_hist[0] ← x_new, and x_new is loaded into the output register.
- Output register holds x and out_valid stable until emitted. Data must not change while out_valid && !out_ready.
- clear = 1:
  - Zeroes y_prev, x_hist, the output register and any skid entry.
  - Forces out_valid = 0 and in_ready = 0 that cycle.
  - clear wins over a simultaneous input handshake; that sample is dropped.
- rst = 1: same effect as clear, and additionally resets every output. Reset asserted mid-stream discards all in-flight data. First accept after rst release is treated as n = 0.
- State machine, two states:
  - RUN: normal operation.
  - FLUSH: entered on clear or rst, lasts exactly one cycle; in_ready = 0 and out_valid = 0. Returns to RUN unconditionally.

## Timing
- Reset values: in_ready = 0 (FLUSH), out_valid = 0, x = 0. in_ready rises the cycle after rst deasserts.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 sample/cycle with out_ready held high.
- in_ready (base build) = (state == RUN) && (!out_valid || out_ready). This is a combinational path from out_ready.
- Simultaneous accept and emit in the same cycle: the output register reloads with no bubble.
- A stall does not advance the history; the history advances only on accept.

## Configuration
- SMA_INV_SKID_EN defined:
  - A 2-entry skid buffer is inserted between the datapath and the x/out_valid outputs.
  - in_ready becomes a pure register output (state == RUN && skid not full), which breaks the out_ready → in_ready path.
  - Latency is still 1 cycle when unstalled. Up to 2 samples may be accepted after out_ready falls.
  - Order is preserved. clear/rst empty the buffer.
- Undefined: single output register with the combinational in_ready above.

## Structure
- Shared package sma_pkg:
  - DATA_W and TAPS defaults.
  - sample_t typedef (signed [DATA_W−1:0]).
  - State enum {RUN, FLUSH}.
  - Shared with the forward SMA filter.
- Sub-module sma_inv_skid: 2-entry valid/ready skid buffer, instantiated only under SMA_INV_SKID_EN.

## Test plan
- Pass-through: y = 1, 3, 6, 10, 14, 18 with out_ready = 1 → x = 1, 2, 3, 4, 5, 6, one cycle after each accept.
- Wrap-around: x = 0x7FFF ×4 run through the forward SMA (y = 0x7FFF, 0xFFFE, 0x7FFD, 0xFFFC) → x = 0x7FFF ×4 exactly.
- Backpressure: out_ready low for 3 cycles mid-stream.
  - Base build: x holds stable, in_ready = 0.
  - SKID build: exactly 2 extra accepts, then in_ready = 0.
  - Both: no loss or duplication; sequence 1..6 preserved.
- clear after y = 1, 3, 6, then y = 5 → x = 5 (history zeroed). A sample offered during the clear cycle is not accepted.
- Reset mid-stream: rst pulsed while out_valid = 1 → out_valid = 0 and x = 0 next cycle; in_ready = 1 one cycle after release; next y = 7 → x = 7.
- Random round trip: 10k random signed x through the forward SMA into this block with random in_valid/out_ready → output equals input bit-exactly.

Source files
------------

// File: rtl/sma_pkg.sv
// sma_pkg -- definitions shared by the forward SMA filter and its inverse.
//
// Contents:
//   DEF_DATA_W : default sample width (signed two's complement)
//   DEF_TAPS   : default SMA window length (must be >= 2)
//   sample_t   : signed sample at the default width
//   state_t    : control state, RUN (normal) / FLUSH (one-cycle history flush)
package sma_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAPS   = 4;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/sma_inv_skid.sv
// sma_inv_skid -- 2-entry valid/ready skid buffer with fall-through when empty.
//
// Ports:
//   clk       : rising-edge clock
//   flush     : synchronous flush, empties the buffer and zeroes its storage
//   in_valid  : upstream data present
//   in_ready  : registered "not full"; never depends on out_ready this cycle
//   in_data   : upstream data
//   out_valid : buffered head (or fall-through data) present
//   out_ready : downstream accepts out_data
//   out_data  : oldest entry, or in_data when the buffer is empty
module sma_inv_skid #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_d;
    logic         full_q;
    logic         empty;
    logic         push;
    logic         pop;

    assign empty     = (count == 2'd0);
    assign in_ready  = !full_q;
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : mem[rd_ptr];

    // An empty buffer with a ready consumer passes data straight through
    // without storing it, which keeps the unstalled latency unchanged.
    assign push = in_valid && !full_q && !(empty && out_ready);
    assign pop  = !empty && out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        count_d = count;
        if (push && !pop) begin
            count_d = count + 2'd1;
        end else if (pop && !push) begin
            count_d = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            full_q <= 1'b0;
            // NOTE: the storage is cleared as well because out_data exposes
            // it; a flushed block must present x = 0.
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count  <= count_d;
            full_q <= (count_d == 2'd2);
        end
    end

endmodule

// File: rtl/sma_inv.sv
// sma_inv -- inverse simple-moving-average filter.
//
// Rebuilds the original samples from a stream of TAPS-tap running sums:
//   x[n] = y[n] - y[n-1] + x[n-TAPS]   (modulo 2^DATA_W)
// History starts at zero, matching the forward filter, so no warm-up.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (flushes history and outputs)
//   clear     : synchronous history flush; wins over a same-cycle accept
//   in_valid  : y present          in_ready  : y accepted this cycle
//   y         : signed SMA sum
//   out_valid : x present          out_ready : x taken this cycle
//   x         : signed reconstructed sample
//
// Build option SMA_INV_SKID_EN: inserts a 2-entry skid buffer in front of
// x/out_valid so in_ready becomes a registered signal with no path from
// out_ready. Without it, a single output register drives x.
module sma_inv
    import sma_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAPS   = DEF_TAPS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] x
);

    state_t                   state_q;
    state_t                   state_d;
    logic                     flush;
    logic                     run_en;
    logic                     accept;
    logic signed [DATA_W-1:0] y_prev;
    logic signed [DATA_W-1:0] x_hist [TAPS];
    logic signed [DATA_W-1:0] x_new;

    assign flush = rst || clear;

    // Control FSM: any flush request lands in FLUSH for one cycle.
    always_comb begin
        state_d = RUN;
        if (flush) begin
            state_d = FLUSH;
        end
        run_en = (state_q == RUN) && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLUSH;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Wrap-around arithmetic is intentional: the forward filter also wraps,
    // so the round trip is exact for every input.
    assign x_new = y - y_prev + x_hist[TAPS-1];

    always_ff @(posedge clk) begin
        if (flush) begin
            y_prev <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_hist[i] <= '0;
            end
        end else if (accept) begin
            y_prev    <= y;
            x_hist[0] <= x_new;
            for (int i = 1; i < TAPS; i++) begin
                x_hist[i] <= x_hist[i-1];
            end
        end
    end

`ifdef SMA_INV_SKID_EN
    logic                     skid_in_ready;
    logic                     skid_out_valid;
    logic                     dp_valid;
    logic signed [DATA_W-1:0] dp_x;

    assign in_ready  = (state_q == RUN) && skid_in_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = skid_out_valid && run_en;

    // The datapath register always drains into the skid buffer while the
    // buffer has room, so it can reload on every accept.
    always_ff @(posedge clk) begin
        if (flush) begin
            dp_valid <= 1'b0;
            dp_x     <= '0;
        end else if (accept) begin
            dp_valid <= 1'b1;
            dp_x     <= x_new;
        end else if (dp_valid && skid_in_ready) begin
            dp_valid <= 1'b0;
        end
    end

    sma_inv_skid #(
        .W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .flush     (flush),
        .in_valid  (dp_valid),
        .in_ready  (skid_in_ready),
        .in_data   (dp_x),
        .out_valid (skid_out_valid),
        .out_ready (out_ready && run_en),
        .out_data  (x)
    );
`else
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] x_q;

    assign out_valid = out_valid_q && run_en;
    assign in_ready  = run_en && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign x         = x_q;

    always_ff @(posedge clk) begin
        if (flush) begin
            out_valid_q <= 1'b0;
            x_q         <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            x_q         <= x_new;
        end else if (out_valid && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sma_inv.sv
// tb_sma_inv -- directed and random round-trip bench for sma_inv.
module tb_sma_inv;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x;

    int checks = 0;
    int errors = 0;

    logic [15:0] stim_q [$];
    logic [15:0] exp_q  [$];
    int          out_cyc_q [$];
    int          last_stall_accepts;

    localparam int N_RAND = 10000;
    logic [15:0] rx [N_RAND];
    logic [15:0] ry [N_RAND];

    sma_inv dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Streams stim_q with out_ready forced low for stall_len cycles starting
    // at cycle stall_at; compares every emitted x against exp_q in order.
    task automatic run_stream(input string name, input int stall_at, input int stall_len);
        int          sent;
        int          recv;
        int          cyc;
        int          stall_acc;
        logic [15:0] held;
        bit          held_ok;
        sent = 0; recv = 0; cyc = 0; stall_acc = 0; held_ok = 0; held = '0;
        out_cyc_q.delete();
        while (recv < exp_q.size() && cyc < 200) begin
            in_valid  = (sent < stim_q.size());
            y         = in_valid ? stim_q[sent] : 16'h0;
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge clk);
            if (!out_ready && out_valid) begin
                if (held_ok) begin
                    checks++;
                    if (x !== held) begin
                        errors++;
                        $display("FAIL %s_hold: x=%h while stalled, required %h", name, x, held);
                    end
                end
                held = x; held_ok = 1;
            end else begin
                held_ok = 0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (x !== exp_q[recv]) begin
                    errors++;
                    $display("FAIL %s_x[%0d]: got %h required %h", name, recv, x, exp_q[recv]);
                end
                out_cyc_q.push_back(cyc);
                recv++;
            end
            if (in_valid && in_ready) begin
                sent++;
                if (!out_ready) stall_acc++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        checks++;
        if (recv != exp_q.size()) begin
            errors++;
            $display("FAIL %s_timeout: got %0d outputs required %0d", name, recv, exp_q.size());
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        last_stall_accepts = stall_acc;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; y = '0;
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (x !== 16'h0)        begin errors++; $display("FAIL rst_x: got %h required 0000", x); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL run_in_ready: got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL run_out_valid: got %b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pass_through();
        do_reset();
        stim_q = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd14, 16'd18};
        exp_q  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        run_stream("pass", 1000, 0);
        // Accepts happen on cycles 0..5, so each x appears one cycle later.
        for (int i = 0; i < out_cyc_q.size(); i++) begin
            checks++;
            if (out_cyc_q[i] !== i + 1) begin
                errors++;
                $display("FAIL pass_latency[%0d]: emitted cycle %0d required %0d", i, out_cyc_q[i], i + 1);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        stim_q = '{16'h7FFF, 16'hFFFE, 16'h7FFD, 16'hFFFC};
        exp_q  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_stream("wrap", 1000, 0);
    endtask

    task automatic test_backpressure();
        int req_acc;
        do_reset();
        stim_q = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd14, 16'd18};
        exp_q  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        run_stream("bp", 2, 3);
`ifdef SMA_INV_SKID_EN
        req_acc = 2;
`else
        req_acc = 0;
`endif
        checks++;
        if (last_stall_accepts !== req_acc) begin
            errors++;
            $display("FAIL bp_stall_accepts: got %0d required %0d", last_stall_accepts, req_acc);
        end
    endtask

    task automatic test_clear();
        do_reset();
        stim_q = '{16'd1, 16'd3, 16'd6};
        exp_q  = '{16'd1, 16'd2, 16'd3};
        run_stream("pre_clear", 1000, 0);
        clear = 1'b1; in_valid = 1'b1; y = 16'd100;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_out_valid: got %b required 0", out_valid); end
`ifndef SMA_INV_SKID_EN
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b required 0", in_ready); end
`endif
        @(posedge clk);
        #1 clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL clear_flush_in_ready: got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_flush_out_valid: got %b required 0", out_valid); end
        if (x !== 16'h0)        begin errors++; $display("FAIL clear_flush_x: got %h required 0000", x); end
        @(posedge clk);
        #1;
        stim_q = '{16'd5};
        exp_q  = '{16'd5};
        run_stream("post_clear", 1000, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; y = 16'd1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_out_valid: got %b required 1", out_valid); end
        if (x !== 16'd1)        begin errors++; $display("FAIL mid_x: got %h required 0001", x); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
        if (x !== 16'h0)        begin errors++; $display("FAIL mid_rst_x: got %h required 0000", x); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_in_ready: got %b required 0", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1 out_ready = 1'b1;
        stim_q = '{16'd7};
        exp_q  = '{16'd7};
        run_stream("post_rst", 1000, 0);
    endtask

    task automatic test_random_round_trip();
        int sent;
        int recv;
        int cyc;
        logic [15:0] s;
        for (int i = 0; i < N_RAND; i++) begin
            rx[i] = 16'($urandom);
        end
        // Forward 4-tap SMA with zero initial history, wrapping at 16 bits.
        for (int i = 0; i < N_RAND; i++) begin
            s = 16'h0;
            for (int k = 0; k < 4; k++) begin
                if (i - k >= 0) s = s + rx[i-k];
            end
            ry[i] = s;
        end
        do_reset();
        sent = 0; recv = 0; cyc = 0;
        while (recv < N_RAND && cyc < 60000) begin
            in_valid  = (sent < N_RAND) && ($urandom_range(3) != 0);
            y         = (sent < N_RAND) ? ry[sent] : 16'h0;
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (x !== rx[recv]) begin
                    errors++;
                    $display("FAIL rand_x[%0d]: got %h required %h", recv, x, rx[recv]);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1 cyc++;
        end
        checks++;
        if (recv != N_RAND) begin
            errors++;
            $display("FAIL rand_timeout: got %0d outputs required %0d", recv, N_RAND);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; y = '0;
        last_stall_accepts = 0;
        test_reset();
        test_pass_through();
        test_wrap();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_random_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
